stripe_controller: RTL
======================

Name: stripe_controller

Overview:
- Sequencer that sits in front of the 4-lane byte-striping datapath.
- Accepts a serial byte stream via a valid/ready handshake and collects one "round" of bytes, one per active lane.
- Presents each completed round on all active lanes simultaneously with a one-cycle lane-valid strobe.
- Supports runtime lane-width configuration (x1/x2/x4) and a flush that pads a partial round with an idle symbol.

Parameters:
- DATA_W, 8, width of each byte and lane word.
- IDLE_BYTE, 8'hBC, pad symbol for unfilled lanes on flush and for inactive lanes.
- CNT_W, 16, width of the emitted-round counter.

Ports:
- stripeCtrlCLK  input  1  block clock, rising edge.
- stripeCtrlRST_N  input  1  asynchronous, active-low reset.
- byteIN  input  DATA_W  incoming byte.
- byteVLD  input  1  byteIN valid.
- byteRDY  output  1  controller can accept a byte this cycle.
- laneMode  input  2  00 = x1 (lane0), 01 = x2 (lanes 0-1), 10/11 = x4.
- flushREQ  input  1  pulse: emit the partial round padded with IDLE_BYTE.
- stripedLane0..stripedLane3  output  DATA_W each  registered lane words.
- laneVLD  output  4  one-cycle strobe; bit i set = stripedLane i carries a new word.
- roundCount  output  CNT_W  number of rounds emitted, wraps.
- busy  output  1  high when in FILL or FLUSH.

Behaviour:
- Reset (async assert, sync release): stripedLane0-3 = IDLE_BYTE, laneVLD = 0, roundCount = 0, byteRDY = 1, busy = 0, state = IDLE, pos = 0.
- Active lane count N = 1/2/4 from laneMode.
  - N is latched into activeN only when a byte is accepted at pos 0.
  - laneMode changes mid-round are ignored until the next round starts.
- Accept: a byte is accepted when byteVLD && byteRDY.
  - It is staged into slot pos; slot k maps to lane k.
  - pos increments by 1.
- States:
  - IDLE (pos = 0): byteRDY = 1. An accept with N > 1 moves to FILL. An accept with N = 1 completes the round immediately and stays in IDLE.
  - FILL (0 < pos < activeN): byteRDY = 1.
    - An accept that makes pos == activeN completes the round; go to IDLE, pos = 0.
    - flushREQ without round completion goes to FLUSH.
  - FLUSH: byteRDY = 0 for exactly one cycle.
    - Slots pos..activeN-1 are filled with IDLE_BYTE and the round completes.
    - Then go to IDLE, pos = 0.
- Round completion in cycle t:
  - In cycle t+1, stripedLane k = slot k for k < activeN, and stripedLane k = IDLE_BYTE for k >= activeN.
  - laneVLD = (1 << activeN) - 1, for one cycle only.
  - roundCount increments by 1, modulo 2^CNT_W.
- Latency: last byte of a round accepted at edge t → laneVLD high during cycle t+1. Flush: flushREQ sampled at t → FLUSH during t+1 → laneVLD during t+2.
- stripedLane outputs hold their last value when laneVLD = 0.
- Simultaneous byteVLD and flushREQ in FILL:
  - The byte is accepted first.
  - If it completes the round, flushREQ is discarded (no empty round is emitted).
  - Otherwise the controller goes to FLUSH with the new byte included.
- flushREQ in IDLE (pos = 0, no accept that cycle): no-op, no empty round emitted.
- flushREQ together with an accept at pos 0 and N > 1: the byte is staged and the controller goes to FLUSH.
- flushREQ during FLUSH: ignored.
- Reset mid-round: the staged partial round is discarded with no laneVLD; the next accepted byte goes to lane0.
- busy = (state != IDLE).

Test Plan:
- Reset check → stripedLane0..3 = 8'hBC, laneVLD = 0, roundCount = 0, byteRDY = 1, busy = 0.
- x4 stream: laneMode = 10, bytes 11,22,33,44 on 4 consecutive cycles → one cycle later lanes = 11/22/33/44, laneVLD = 4'b1111 for 1 cycle, roundCount = 1.
- x2 stream: laneMode = 01, bytes A1,A2,A3,A4 → two strobes of laneVLD = 4'b0011, lanes0-1 = A1/A2 then A3/A4, lanes2-3 = BC, roundCount = 2.
- Flush partial round: x4, bytes 55,66 then flushREQ → byteRDY low one cycle, then lanes = 55/66/BC/BC with laneVLD = 4'b1111. flushREQ in IDLE → no strobe.
- Mode change mid-round: x4, byte 01, set laneMode = 00, bytes 02,03,04 → emits 01/02/03/04 with 4'b1111. Next byte 05 → lane0 = 05, laneVLD = 4'b0001.
- Async reset after 3 of 4 bytes → no strobe. Subsequent bytes 0A,0B,0C,0D emit in lanes 0-3. Separately, roundCount preloaded near wrap (force 16'hFFFF) wraps to 0.

Source files
------------

// File: rtl/stripe_controller.sv
// Sequencer in front of the 4-lane byte-striping datapath.
// Collects one byte per active lane from a valid/ready byte stream, then presents the
// whole round on the lanes at once with a one-cycle lane-valid strobe. A flush pads a
// partial round with IDLE_BYTE. Lane width (x1/x2/x4) is sampled at the start of a round.
//
// Ports:
//   stripeCtrlCLK     clock, rising edge
//   stripeCtrlRST_N   asynchronous active-low reset
//   byteIN/byteVLD    incoming byte and its valid
//   byteRDY           a byte can be accepted this cycle (low only in FLUSH)
//   laneMode          00 = x1, 01 = x2, 1x = x4
//   flushREQ          emit the partial round padded with IDLE_BYTE
//   stripedLane0..3   registered lane words, hold when laneVLD = 0
//   laneVLD           one-cycle strobe, one bit per active lane
//   roundCount        emitted rounds, wraps
//   busy              controller is in FILL or FLUSH
module stripe_controller #(
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_BYTE = DATA_W'(8'hBC),
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              stripeCtrlCLK,
  input  logic              stripeCtrlRST_N,
  input  logic [DATA_W-1:0] byteIN,
  input  logic              byteVLD,
  output logic              byteRDY,
  input  logic [1:0]        laneMode,
  input  logic              flushREQ,
  output logic [DATA_W-1:0] stripedLane0,
  output logic [DATA_W-1:0] stripedLane1,
  output logic [DATA_W-1:0] stripedLane2,
  output logic [DATA_W-1:0] stripedLane3,
  output logic [3:0]        laneVLD,
  output logic [CNT_W-1:0]  roundCount,
  output logic              busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFill  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [2:0]        pos_q, pos_d;
  logic [2:0]        active_n_q, active_n_d;
  logic [DATA_W-1:0] slot_q [4];
  logic [DATA_W-1:0] slot_d [4];
  logic [DATA_W-1:0] lane_q [4];
  logic [DATA_W-1:0] lane_d [4];
  logic [3:0]        lane_vld_q, lane_vld_d;
  logic [CNT_W-1:0]  round_cnt_q, round_cnt_d;

  logic       accept;
  logic [2:0] mode_n;
  logic [2:0] eff_n;
  logic [2:0] fill_cnt;
  logic       complete;
  logic [4:0] vld_mask;

  assign byteRDY = (state_q != StFlush);
  assign busy    = (state_q != StIdle);
  assign accept  = byteVLD & byteRDY;

  always_comb begin
    unique case (laneMode)
      2'b00:   mode_n = 3'd1;
      2'b01:   mode_n = 3'd2;
      default: mode_n = 3'd4;
    endcase
  end

  // The lane count of a round is the live mode only for its first byte; afterwards the
  // latched copy applies so mid-round mode changes cannot reshape the round.
  assign eff_n    = (pos_q == 3'd0) ? mode_n : active_n_q;
  assign fill_cnt = pos_q + {2'b00, accept};
  assign complete = (state_q == StFlush) || (accept && (fill_cnt == eff_n));
  assign vld_mask = (5'd1 << eff_n) - 5'd1;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    active_n_d  = active_n_q;
    slot_d      = slot_q;
    lane_d      = lane_q;
    lane_vld_d  = 4'b0000;
    round_cnt_d = round_cnt_q;

    if (accept) begin
      slot_d[pos_q[1:0]] = byteIN;
      if (pos_q == 3'd0) begin
        active_n_d = mode_n;
      end
    end

    if (complete) begin
      // Lanes beyond the filled count (flush padding or inactive lanes) carry IDLE_BYTE;
      // the byte accepted this cycle bypasses the slot register.
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < fill_cnt) begin
          lane_d[k] = (accept && (pos_q[1:0] == 2'(k))) ? byteIN : slot_q[k];
        end else begin
          lane_d[k] = IDLE_BYTE;
        end
      end
      lane_vld_d  = vld_mask[3:0];
      round_cnt_d = round_cnt_q + 1'b1;
      state_d     = StIdle;
      pos_d       = 3'd0;
    end else if (accept) begin
      pos_d   = fill_cnt;
      state_d = flushREQ ? StFlush : StFill;
    end else if ((state_q == StFill) && flushREQ) begin
      state_d = StFlush;
    end
  end

  always_ff @(posedge stripeCtrlCLK or negedge stripeCtrlRST_N) begin
    if (!stripeCtrlRST_N) begin
      state_q     <= StIdle;
      pos_q       <= 3'd0;
      active_n_q  <= 3'd1;
      lane_vld_q  <= 4'b0000;
      round_cnt_q <= '0;
      for (int k = 0; k < 4; k++) begin
        slot_q[k] <= IDLE_BYTE;
        lane_q[k] <= IDLE_BYTE;
      end
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      active_n_q  <= active_n_d;
      lane_vld_q  <= lane_vld_d;
      round_cnt_q <= round_cnt_d;
      for (int k = 0; k < 4; k++) begin
        slot_q[k] <= slot_d[k];
        lane_q[k] <= lane_d[k];
      end
    end
  end

  assign stripedLane0 = lane_q[0];
  assign stripedLane1 = lane_q[1];
  assign stripedLane2 = lane_q[2];
  assign stripedLane3 = lane_q[3];
  assign laneVLD      = lane_vld_q;
  assign roundCount   = round_cnt_q;

endmodule
